// File: rtl/vjtag_reg_bridge.sv
// Virtual JTAG register bridge: multi-bit IR decoder driving an
// addressable register port with auto-increment and a sticky scan-error bit.
module vjtag_reg_bridge #(
    parameter int          IR_WIDTH   = 3,
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 4,
    parameter logic [31:0] ID_VALUE   = 32'h0000_1A5A
) (
    input  logic                  tck,
    input  logic                  rst,
    input  logic                  tdi,
    output logic                  tdo,
    input  logic [IR_WIDTH-1:0]   ir_in,
    output logic [IR_WIDTH-1:0]   ir_out,
    input  logic                  virtual_state_cdr,
    input  logic                  virtual_state_sdr,
    input  logic                  virtual_state_e1dr,
    input  logic                  virtual_state_pdr,
    input  logic                  virtual_state_e2dr,
    input  logic                  virtual_state_udr,
    input  logic                  virtual_state_cir,
    input  logic                  virtual_state_uir,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_strobe,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_strobe
);

    typedef enum logic [2:0] {
        OP_BYPASS, OP_IDCODE, OP_ADDR, OP_READ, OP_WRITE
    } op_e;

    localparam int CW = $clog2(DATA_WIDTH + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_DW  = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_AW  = CW'(ADDR_WIDTH);

    function automatic op_e decode(input logic [IR_WIDTH-1:0] ir);
        case (ir)
            IR_WIDTH'(1): decode = OP_IDCODE;
            IR_WIDTH'(2): decode = OP_ADDR;
            IR_WIDTH'(3): decode = OP_READ;
            IR_WIDTH'(4): decode = OP_WRITE;
            default:      decode = OP_BYPASS;
        endcase
    endfunction

    op_e                   cur_op;
    op_e                   op_q, op_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic                  byp_q, byp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [IR_WIDTH-1:0]   ir_out_q, ir_out_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_stb_q, wr_stb_d;
    logic                  hold_st;

    assign cur_op  = decode(ir_in);
    assign hold_st = virtual_state_e1dr | virtual_state_pdr | virtual_state_e2dr;

    assign tdo       = (op_q == OP_BYPASS) ? byp_q : sr_q[0];
    assign ir_out    = ir_out_q;
    assign reg_addr  = addr_q;
    assign wr_data   = wr_data_q;
    assign wr_strobe = wr_stb_q;
    // Read strobe marks the capture cycle in which rd_data is sampled into sr
    assign rd_strobe = ~rst & virtual_state_cdr & (cur_op == OP_READ);

    // Next-state: DR capture/shift/update, IR capture/update and write-address bump
    always_comb begin
        op_d      = op_q;
        sr_d      = sr_q;
        byp_d     = byp_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ir_out_d  = ir_out_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_stb_d  = 1'b0;

        // Address moves on only after the write pulse has been seen
        if (wr_stb_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        if (virtual_state_cdr) begin
            op_d  = cur_op;
            cnt_d = '0;
            case (cur_op)
                OP_IDCODE: sr_d  = DATA_WIDTH'(ID_VALUE);
                OP_ADDR:   sr_d  = DATA_WIDTH'(addr_q);
                OP_READ:   sr_d  = rd_data;
                OP_WRITE:  sr_d  = '0;
                default:   byp_d = 1'b0;
            endcase
        end else if (virtual_state_sdr) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
            case (op_q)
                OP_BYPASS: byp_d = tdi;
                OP_ADDR: begin
                    for (int i = 0; i < ADDR_WIDTH - 1; i++) begin
                        sr_d[i] = sr_q[i+1];
                    end
                    sr_d[ADDR_WIDTH-1] = tdi;
                end
                default: sr_d = {tdi, sr_q[DATA_WIDTH-1:1]};
            endcase
        end else if (virtual_state_udr) begin
            case (op_q)
                OP_ADDR: begin
                    if (cnt_q == CNT_AW) addr_d = sr_q[ADDR_WIDTH-1:0];
                    else                 err_d  = 1'b1;
                end
                OP_READ: begin
                    if (cnt_q == CNT_DW) addr_d = addr_q + ADDR_WIDTH'(1);
                    else                 err_d  = 1'b1;
                end
                OP_WRITE: begin
                    if (cnt_q == CNT_DW) begin
                        wr_data_d = sr_q;
                        wr_stb_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (hold_st) begin
            // Exit/pause states freeze the scan
        end

        if (virtual_state_cir) begin
            ir_out_d = {{(IR_WIDTH-1){1'b0}}, err_q};
        end
        if (virtual_state_uir && cur_op == OP_ADDR) begin
            err_d = 1'b0;
        end
    end

    // State registers with asynchronous reset aborting any scan in flight
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            op_q      <= OP_BYPASS;
            sr_q      <= '0;
            byp_q     <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ir_out_q  <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_stb_q  <= 1'b0;
        end else begin
            op_q      <= op_d;
            sr_q      <= sr_d;
            byp_q     <= byp_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ir_out_q  <= ir_out_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_stb_q  <= wr_stb_d;
        end
    end

endmodule

// File: tb/tb_vjtag_reg_bridge.sv
// Directed bench for vjtag_reg_bridge: scans IDCODE/ADDR/READ/WRITE/BYPASS,
// length errors, error clearing and reset mid-scan.
module tb_vjtag_reg_bridge;

    logic        tck = 1'b0;
    logic        rst, tdi, tdo;
    logic [2:0]  ir_in, ir_out;
    logic        cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;
    logic [3:0]  reg_addr;
    logic [31:0] wr_data, rd_data;
    logic        wr_strobe, rd_strobe;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, rd_cnt = 0, overlap = 0, wr_run = 0, rd_run = 0;
    logic        wr_prev = 1'b0, rd_prev = 1'b0;
    logic [3:0]  last_wr_addr = '0, last_rd_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [63:0] dout, din, exp_v;

    vjtag_reg_bridge dut (
        .tck(tck), .rst(rst), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr),
        .virtual_state_e1dr(e1dr), .virtual_state_pdr(pdr),
        .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir),
        .reg_addr(reg_addr), .wr_data(wr_data), .wr_strobe(wr_strobe),
        .rd_data(rd_data), .rd_strobe(rd_strobe)
    );

    always #5 tck = ~tck;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Strobe monitor, sampled mid-cycle
    always @(negedge tck) begin
        if (wr_strobe) begin
            wr_cnt++;
            last_wr_addr = reg_addr;
            last_wr_data = wr_data;
            if (wr_prev) wr_run++;
        end
        if (rd_strobe) begin
            rd_cnt++;
            last_rd_addr = reg_addr;
            if (rd_prev) rd_run++;
        end
        if (wr_strobe && rd_strobe) overlap++;
        wr_prev = wr_strobe;
        rd_prev = rd_strobe;
    end

    task automatic tick;
        @(posedge tck);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic dr_scan(input logic [2:0] ir, input int n,
                           input logic [63:0] d, output logic [63:0] q);
        q = '0;
        ir_in = ir;
        cdr = 1'b1;
        tick();
        cdr = 1'b0;
        sdr = 1'b1;
        for (int i = 0; i < n; i++) begin
            tdi = d[i];
            q[i] = tdo;
            tick();
        end
        sdr = 1'b0;
        tdi = 1'b0;
        e1dr = 1'b1;
        tick();
        e1dr = 1'b0;
        udr = 1'b1;
        tick();
        udr = 1'b0;
        tick();
    endtask

    task automatic ir_capture;
        cir = 1'b1;
        tick();
        cir = 1'b0;
        tick();
    endtask

    task automatic ir_update(input logic [2:0] ir);
        ir_in = ir;
        uir = 1'b1;
        tick();
        uir = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; tdi = 1'b0; ir_in = '0;
        cdr = 0; sdr = 0; e1dr = 0; pdr = 0; e2dr = 0; udr = 0; cir = 0; uir = 0;
        rd_data = 32'h1234_5678;
        tick();
        tick();
        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_ir_out", 64'(ir_out), 64'd0);
        check("rst_addr", 64'(reg_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_wr_strobe", 64'(wr_strobe), 64'd0);
        check("rst_rd_strobe", 64'(rd_strobe), 64'd0);
        rst = 1'b0;
        tick();

        // IDCODE
        dr_scan(3'd1, 32, 64'd0, dout);
        check("idcode_tdo", dout, 64'h0000_1A5A);
        check("idcode_addr", 64'(reg_addr), 64'd0);
        check("idcode_strobes", 64'(wr_cnt + rd_cnt), 64'd0);
        ir_capture();
        check("ir_out_clean", 64'(ir_out), 64'd0);

        // ADDR = 14
        dr_scan(3'd2, 4, 64'hE, dout);
        check("addr_old", dout, 64'd0);
        check("addr_set", 64'(reg_addr), 64'd14);

        // Two writes, the second wrapping the address
        dr_scan(3'd4, 32, 64'hDEAD_BEEF, dout);
        check("wr1_tdo", dout, 64'd0);
        check("wr1_cnt", 64'(wr_cnt), 64'd1);
        check("wr1_addr", 64'(last_wr_addr), 64'd14);
        check("wr1_data", 64'(last_wr_data), 64'hDEAD_BEEF);
        check("wr1_inc", 64'(reg_addr), 64'd15);
        dr_scan(3'd4, 32, 64'hDEAD_BEEF, dout);
        check("wr2_cnt", 64'(wr_cnt), 64'd2);
        check("wr2_addr", 64'(last_wr_addr), 64'd15);
        check("wr2_wrap", 64'(reg_addr), 64'd0);

        // READ
        dr_scan(3'd3, 32, 64'd0, dout);
        check("rd_tdo", dout, 64'h1234_5678);
        check("rd_cnt", 64'(rd_cnt), 64'd1);
        check("rd_addr", 64'(last_rd_addr), 64'd0);
        check("rd_inc", 64'(reg_addr), 64'd1);

        // Short and long writes
        dr_scan(3'd4, 31, 64'hFFFF_FFFF_FFFF_FFFF, dout);
        check("short_nowr", 64'(wr_cnt), 64'd2);
        check("short_addr", 64'(reg_addr), 64'd1);
        dr_scan(3'd4, 33, 64'hFFFF_FFFF_FFFF_FFFF, dout);
        check("long_nowr", 64'(wr_cnt), 64'd2);
        check("long_addr", 64'(reg_addr), 64'd1);
        ir_capture();
        check("err_set", 64'(ir_out), 64'd1);
        ir_update(3'd2);
        ir_capture();
        check("err_clr", 64'(ir_out), 64'd0);

        // ADDR readback of current address, then move to 3
        dr_scan(3'd2, 4, 64'h3, dout);
        check("addr_rb", dout, 64'd1);
        check("addr_set3", 64'(reg_addr), 64'd3);

        // BYPASS via code 0 and code 7
        din = 64'hB2;
        exp_v = (din << 1) & 64'hFF;
        dr_scan(3'd0, 8, din, dout);
        check("byp0_tdo", dout, exp_v);
        dr_scan(3'd7, 8, din, dout);
        check("byp7_tdo", dout, exp_v);
        check("byp_strobes", 64'(wr_cnt + rd_cnt), 64'd3);
        check("byp_addr", 64'(reg_addr), 64'd3);

        // Reset in the middle of a WRITE shift
        ir_in = 3'd4;
        cdr = 1'b1;
        tick();
        cdr = 1'b0;
        sdr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tdi = 1'b1;
            tick();
        end
        rst = 1'b1;
        #1;
        check("mrst_addr", 64'(reg_addr), 64'd0);
        check("mrst_wr_data", 64'(wr_data), 64'd0);
        check("mrst_tdo", 64'(tdo), 64'd0);
        check("mrst_ir_out", 64'(ir_out), 64'd0);
        sdr = 1'b0;
        tdi = 1'b0;
        tick();
        rst = 1'b0;
        udr = 1'b1;
        tick();
        udr = 1'b0;
        tick();
        tick();
        check("mrst_nowr", 64'(wr_cnt), 64'd2);
        check("mrst_addr2", 64'(reg_addr), 64'd0);
        ir_capture();
        check("mrst_err", 64'(ir_out), 64'd0);

        check("overlap", 64'(overlap), 64'd0);
        check("wr_run", 64'(wr_run), 64'd0);
        check("rd_run", 64'(rd_run), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vjtag_reg_bridge.md
Name: vjtag_reg_bridge

Overview:
Parametrised successor to the 1-bit-IR virtual JTAG endpoint. It sits directly behind the virtual JTAG instance, clocked on tck, and decodes a multi-bit IR into BYPASS, IDCODE, ADDR, READ and WRITE instructions. It provides an addressable register-access port: a host scans an address, then reads or writes DATA_WIDTH-bit words with address auto-increment. Malformed scans are flagged by a sticky error bit returned through ir_out.

Parameters:
IR_WIDTH, 3, instruction register width; minimum 3.
DATA_WIDTH, 32, data scan length and register word width.
ADDR_WIDTH, 4, register address width.
ID_VALUE, 32'h0000_1A5A, value captured by IDCODE; zero-extended or truncated to DATA_WIDTH.

Ports:
tck  input  1  JTAG clock; the only clock, all state on rising edge.
rst  input  1  asynchronous active-high reset.
tdi  input  1  serial data from the virtual JTAG.
tdo  output  1  serial data to the virtual JTAG.
ir_in  input  IR_WIDTH  current instruction.
ir_out  output  IR_WIDTH  status returned on IR capture.
virtual_state_cdr/sdr/e1dr/pdr/e2dr/udr/cir/uir  input  1 each  TAP state indicators.
reg_addr  output  ADDR_WIDTH  current register address.
wr_data  output  DATA_WIDTH  write data; valid while wr_strobe is high.
wr_strobe  output  1  one-tck write pulse.
rd_data  input  DATA_WIDTH  combinational read of reg_addr, sampled on rd_strobe.
rd_strobe  output  1  one-tck read pulse.

Behaviour:
- Reset is asynchronous and active-high. On reset: tdo=0, ir_out=0, reg_addr=0, wr_data=0, wr_strobe=0, rd_strobe=0. The shift register, bypass flop, bit counter, latched opcode and error flag are all cleared. Reset mid-scan aborts the scan; no strobe is generated.
- Opcode decode: 0=BYPASS, 1=IDCODE, 2=ADDR, 3=READ, 4=WRITE. All other codes act as BYPASS.
- Opcode latch: ir_in is latched into op at CDR and used until the next CDR. A change on ir_in mid-scan has no effect on that scan.
- State priority: if more than one state input is high, the order is cdr > sdr > udr. e1dr, pdr and e2dr hold all state.
- CDR actions:
  - bit counter <= 0.
  - BYPASS: bypass <= 0.
  - IDCODE: sr <= ID_VALUE.
  - ADDR: sr <= zero-extended reg_addr.
  - READ: sr <= rd_data, and rd_strobe is high in that same cycle.
  - WRITE: sr <= 0.
- SDR shifting (LSB first):
  - BYPASS: bypass <= tdi.
  - ADDR: the shift length is ADDR_WIDTH. tdi enters at sr[ADDR_WIDTH-1], and upper bits hold.
  - All other opcodes: sr <= {tdi, sr[DATA_WIDTH-1:1]}.
  - Bit counter increments and saturates at DATA_WIDTH+1.
- tdo: bypass in BYPASS, otherwise sr[0]. It is registered-path only, with no combinational path from tdi.
- Expected length: ADDR_WIDTH for ADDR, DATA_WIDTH for READ and WRITE.
- UDR actions:
  - ADDR: count == ADDR_WIDTH gives reg_addr <= sr[ADDR_WIDTH-1:0].
  - READ: count == DATA_WIDTH gives reg_addr <= reg_addr+1.
  - WRITE: count == DATA_WIDTH gives wr_data <= sr and a one-cycle wr_strobe pulse on the following tck. reg_addr increments one cycle after the pulse, so wr_strobe is seen with the pre-increment address.
  - Address wrap: 2^ADDR_WIDTH-1 rolls to 0.
  - Length mismatch on ADDR/READ/WRITE (short or over-shift): no address change, no write, error flag set to 1 (sticky).
  - IDCODE and BYPASS: UDR has no effect.
- CIR: ir_out <= {zeros, err}.
- UIR with ir_in == ADDR clears err.
- Strobes are never high for more than one consecutive tck. wr_strobe and rd_strobe are never high together.

Test Plan:
- Reset, then IR=IDCODE, 32 shifts -> tdo emits 0x00001A5A LSB first; reg_addr=0, no strobes.
- IR=ADDR, shift 4'hE, UDR; then IR=WRITE, shift 0xDEADBEEF twice -> wr_strobe at addr 14 with 0xDEADBEEF, then at addr 15; reg_addr wraps to 0.
- IR=READ with rd_data=0x12345678 -> rd_strobe one cycle at CDR; tdo yields 0x12345678; reg_addr increments by 1 after UDR.
- IR=WRITE, 31 shifts then UDR; repeat with 33 shifts -> no wr_strobe, reg_addr unchanged, next CIR gives ir_out=3'b001; UIR with ir_in=2 clears it, next CIR gives 0.
- IR=BYPASS (also code 7) -> tdo is tdi delayed by one tck; no strobes.
- Assert rst during a WRITE shift at bit 20 -> all outputs return to reset values immediately; no wr_strobe follows.
